// File: rtl/gather_fifo_pkg.sv
// gather_fifo_pkg: accumulator-width/queue-depth defaults and the lane-rotation helper.
`ifndef ACCW
`define ACCW 8
`endif
`ifndef QDEPTH
`define QDEPTH 4
`endif

package gather_fifo_pkg;
    localparam int LANES = 3;

    function automatic logic [LANES-1:0] rot_sel(input logic [LANES-1:0] s);
        return {s[LANES-2:0], s[LANES-1]};
    endfunction
endpackage

// File: rtl/gather_lane.sv
// gather_lane: single-lane show-ahead FIFO; head word is always visible on dout.
module gather_lane #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int ID    = 0,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; cnt_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = cnt_q;
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);

    a_no_overrun: assert property (@(posedge clk) disable iff (rst) !(push && full) && !(pop && empty))
        else $error("gather_lane %0d: push while full or pop while empty", ID);
endmodule

// File: rtl/gather_fifo.sv
// gather_fifo: narrow-to-wide FIFO; three lanes written round-robin, popped together.
module gather_fifo
    import gather_fifo_pkg::*;
#(
    parameter int IDW   = `ACCW,
    parameter int ODW   = 3*`ACCW,
    parameter int DEPTH = `QDEPTH,
    parameter int ID    = 0,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [IDW-1:0] wr_data,
    output logic           wr_ok,
    input  logic           rd_en,
    output logic [ODW-1:0] rd_data,
    output logic           rd_ok,
    output logic [AW:0]    usedw
);
    logic [LANES-1:0] wsel_q, wsel_d;
    logic [LANES-1:0] lane_full, lane_empty, lane_push;
    logic [IDW-1:0]   lane_dout [LANES];
    logic [AW:0]      lane_cnt  [LANES];
    logic             pop;

    // Lanes fill in order, so lane 2 empty covers the whole group being incomplete.
    assign wr_ok     = ~|(wsel_q & lane_full);
    assign rd_ok     = ~|lane_empty;
    assign pop       = rd_en && rd_ok;
    assign lane_push = {LANES{wr_en && wr_ok}} & wsel_q;

    always_comb wsel_d = (wr_en && wr_ok) ? rot_sel(wsel_q) : wsel_q;

    always_ff @(posedge clk) begin
        if (rst) wsel_q <= LANES'(1);
        else     wsel_q <= wsel_d;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gather_lane #(.DW(IDW), .DEPTH(DEPTH), .ID(ID), .AW(AW)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .push  (lane_push[i]),
            .din   (wr_data),
            .pop   (pop),
            .dout  (lane_dout[i]),
            .count (lane_cnt[i]),
            .full  (lane_full[i]),
            .empty (lane_empty[i])
        );
    end

    assign rd_data = {lane_dout[2], lane_dout[1], lane_dout[0]};
    assign usedw   = lane_cnt[2];

    a_lane_order: assert property (@(posedge clk) disable iff (rst)
        lane_cnt[0] >= lane_cnt[1] && lane_cnt[1] >= lane_cnt[2] && lane_cnt[0] - lane_cnt[2] <= (AW+1)'(1))
        else $error("gather_fifo %0d: lane fill order broken", ID);
endmodule

// File: tb/tb_gather_fifo.sv
// tb_gather_fifo: scoreboard bench; expected wide words queued on write, compared on pop.
module tb_gather_fifo;
    localparam int IDW   = `ACCW;
    localparam int ODW   = 3*IDW;
    localparam int DEPTH = `QDEPTH;
    localparam int AW    = $clog2(DEPTH);

    logic           clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
    logic [IDW-1:0] wr_data = '0;
    logic           wr_ok, rd_ok;
    logic [ODW-1:0] rd_data;
    logic [AW:0]    usedw;

    always #5 clk = ~clk;

    gather_fifo #(.IDW(IDW), .ODW(ODW), .DEPTH(DEPTH), .ID(0), .AW(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_ok(wr_ok),
        .rd_en(rd_en), .rd_data(rd_data), .rd_ok(rd_ok), .usedw(usedw)
    );

    logic [ODW-1:0] mq [$];
    logic [IDW-1:0] pw [3];
    logic [ODW-1:0] last_pop;
    int psel, n_pop, n_chk, n_fail;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lane_cnt(input int i);
        return mq.size() + ((i < psel) ? 1 : 0);
    endfunction

    function automatic logic model_wr_ok();
        return lane_cnt(psel) < DEPTH;
    endfunction

    task automatic step(input logic we, input logic [IDW-1:0] wd, input logic re);
        logic ewr, erd;
        wr_en = we; wr_data = wd; rd_en = re;
        ewr = model_wr_ok();
        erd = (mq.size() != 0);
        #1;
        check("wr_ok", wr_ok, ewr);
        check("rd_ok", rd_ok, erd);
        check("usedw", usedw, mq.size());
        if (erd) check("rd_data", rd_data, mq[0]);
        @(posedge clk); #1;
        if (re && erd) begin
            last_pop = mq.pop_front();
            n_pop++;
        end
        if (we && ewr) begin
            pw[psel] = wd;
            psel++;
            if (psel == 3) begin
                mq.push_back({pw[2], pw[1], pw[0]});
                psel = 0;
            end
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        psel = 0;
    endtask

    initial begin
        logic [ODW-1:0] exp_w;
        int sent, pops0;
        logic we, acc;
        n_chk = 0; n_fail = 0; n_pop = 0; psel = 0;

        do_reset();
        check("rst_wr_ok", wr_ok, 1);
        check("rst_rd_ok", rd_ok, 0);
        check("rst_usedw", usedw, 0);

        step(1, IDW'('h11), 0);
        step(1, IDW'('h22), 0);
        step(1, IDW'('h33), 0);
        exp_w = {IDW'('h33), IDW'('h22), IDW'('h11)};
        check("first_rd_ok", rd_ok, 1);
        check("first_word", rd_data, exp_w);
        check("first_usedw", usedw, 1);
        step(0, '0, 1);
        check("pop_rd_ok", rd_ok, 0);
        check("pop_usedw", usedw, 0);

        step(1, IDW'('hA1), 0);
        step(1, IDW'('hA2), 0);
        step(0, '0, 1);
        check("partial_rd_ok", rd_ok, 0);
        step(1, IDW'('hA3), 0);
        exp_w = {IDW'('hA3), IDW'('hA2), IDW'('hA1)};
        check("partial_word", rd_data, exp_w);
        step(0, '0, 1);

        for (int i = 0; i < 3*DEPTH; i++) step(1, IDW'(i + 'h40), 0);
        check("full_usedw", usedw, DEPTH);
        check("full_wr_ok", wr_ok, 0);
        step(1, IDW'('hFF), 0);
        check("drop_usedw", usedw, DEPTH);
        step(0, '0, 1);
        check("after_pop_wr_ok", wr_ok, 1);
        step(1, IDW'('hFF), 0);
        step(1, IDW'('hFE), 0);
        step(1, IDW'('hFD), 0);
        for (int i = 0; i < DEPTH + 2 && mq.size() != 0; i++) step(0, '0, 1);
        check("drain_empty", rd_ok, 0);
        exp_w = {IDW'('hFD), IDW'('hFE), IDW'('hFF)};
        check("ff_in_lane0", last_pop, exp_w);

        do_reset();
        sent = 0;
        pops0 = n_pop;
        for (int c = 0; c < 400 && (sent < 10*DEPTH || mq.size() != 0); c++) begin
            we = (sent < 10*DEPTH);
            acc = we && model_wr_ok();
            step(we, IDW'(sent + 1), mq.size() != 0);
            if (acc) sent++;
        end
        check("stream_sent", sent, 10*DEPTH);
        check("stream_pops", n_pop - pops0, (10*DEPTH)/3);
        check("stream_drained", mq.size(), 0);

        step(1, IDW'('h01), 0);
        step(1, IDW'('h02), 0);
        do_reset();
        step(1, IDW'('h03), 0);
        step(1, IDW'('h04), 0);
        step(1, IDW'('h05), 0);
        exp_w = {IDW'('h05), IDW'('h04), IDW'('h03)};
        check("rst_mid_word", rd_data, exp_w);
        check("rst_mid_usedw", usedw, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
